updown_key_counter: RTL and testbench

//  Three-key debounced up/down counter. Successor to the single-key counter top level.
//  Up, down and clear keys each have a debouncer. Up/down support hold-to-auto-repeat.
//  The count range is programmable (0..MAX_VALUE), with wrap or saturate selectable at run time.

---
 rtl/updown_counter_pkg.sv | 24 ++
 rtl/key_debounce.sv | 60 ++++++
 rtl/updown_key_counter.sv | 182 ++++++++++++++++++
 tb/tb_updown_key_counter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the three-key up/down counter.
//   rpt_state_t : auto-repeat FSM states
//   clog2       : ceiling log2, used to size debounce and repeat timers
package updown_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned     r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronise and debounce one raw push-button.
//   clk_i, rstn_i : clock, async active-low reset
//   key_i         : raw asynchronous key, active-high
//   debkey_o      : debounced level
//   press_o       : one-cycle pulse, registered with the rising debounced level
// The level flips only after DELAY consecutive cycles of the synchronised key
// disagreeing with it; any agreeing cycle restarts the count.
module key_debounce
  import updown_counter_pkg::*;
#(
  parameter int unsigned DELAY = 1000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic debkey_o,
  output logic press_o
);

  localparam int unsigned CW = (clog2(DELAY) < 1) ? 1 : clog2(DELAY);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DELAY - 1)) begin
        deb_d   = ~deb_q;
        press_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign debkey_o = deb_q;
  assign press_o  = press_q;

endmodule

// File: rtl/updown_key_counter.sv
// Three-key debounced up/down counter with hold-to-auto-repeat.
//   clk_i, rstn_i                   : clock, async active-low reset
//   up_key_i, down_key_i, clr_key_i : raw push-buttons, active-high
//   sat_mode_i                      : 1 = saturate at 0/MAX_VALUE, 0 = wrap
//   count_o                         : registered count, 0..MAX_VALUE
//   wrap_o                          : one-cycle pulse on a wrap in either direction
//   at_max_o, at_min_o              : registered limit flags
//
// Repeat FSM (one each for up and down)
//   state | meaning
//   IDLE  | key not held; a press pulse steps once and enters HOLD
//   HOLD  | held; steps again after REPEAT_DELAY cycles, then RPT
//   RPT   | held; steps every REPEAT_PERIOD cycles
module updown_key_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter int unsigned MAX_VALUE     = 255,
  parameter int unsigned DEB_DELAY     = 1000000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   up_key_i,
  input  logic                   down_key_i,
  input  logic                   clr_key_i,
  input  logic                   sat_mode_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   wrap_o,
  output logic                   at_max_o,
  output logic                   at_min_o
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW      = (clog2(TMR_MAX) < 1) ? 1 : clog2(TMR_MAX);
  localparam logic [COUNT_WIDTH-1:0] MAXV = COUNT_WIDTH'(MAX_VALUE);

  // index 0 = up, 1 = down
  logic [1:0] deb_lvl;
  logic [1:0] press;
  logic [1:0] step;
  logic       clr_press;
  logic       clr_lvl_unused;

  key_debounce #(.DELAY(DEB_DELAY)) u_deb_up (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .key_i    (up_key_i),
    .debkey_o (deb_lvl[0]),
    .press_o  (press[0])
  );

  key_debounce #(.DELAY(DEB_DELAY)) u_deb_down (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .key_i    (down_key_i),
    .debkey_o (deb_lvl[1]),
    .press_o  (press[1])
  );

  key_debounce #(.DELAY(DEB_DELAY)) u_deb_clr (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .key_i    (clr_key_i),
    .debkey_o (clr_lvl_unused),
    .press_o  (clr_press)
  );

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_t    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          step_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state_q <= IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    // Release wins over a timer expiry in the same cycle: no step on the way out.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      step_d  = 1'b0;
      if (!REPEAT_EN) begin
        state_d = IDLE;
        tmr_d   = '0;
        step_d  = press[g];
      end else begin
        case (state_q)
          IDLE: begin
            tmr_d = '0;
            if (press[g]) begin
              state_d = HOLD;
              step_d  = 1'b1;
            end
          end
          HOLD: begin
            if (!deb_lvl[g]) begin
              state_d = IDLE;
              tmr_d   = '0;
            end else if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
              state_d = RPT;
              tmr_d   = '0;
              step_d  = 1'b1;
            end
          end
          RPT: begin
            if (!deb_lvl[g]) begin
              state_d = IDLE;
              tmr_d   = '0;
            end else if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
              tmr_d  = '0;
              step_d = 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            tmr_d   = '0;
          end
        endcase
      end
    end

    assign step[g] = step_d;
  end

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrap_q, wrap_d;
  logic                   at_max_q, at_min_q;

  // Limits are compared before the +/-1 so unused codes above MAX_VALUE are never produced.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_press) begin
      count_d = '0;
    end else if (step[0] ^ step[1]) begin
      if (step[0]) begin
        if (count_q < MAXV) begin
          count_d = count_q + 1'b1;
        end else if (!sat_mode_i) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (!sat_mode_i) begin
          count_d = MAXV;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      at_max_q <= (count_d == MAXV);
      at_min_q <= (count_d == '0);
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = at_max_q;
  assign at_min_o = at_min_q;

endmodule

// File: tb/tb_updown_key_counter.sv
module tb_updown_key_counter;

  localparam int CW   = 4;
  localparam int MAXV = 9;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic          clk_i      = 1'b0;
  logic          rstn_i     = 1'b0;
  logic          up_key_i   = 1'b0;
  logic          down_key_i = 1'b0;
  logic          clr_key_i  = 1'b0;
  logic          sat_mode_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          wrap_o;
  logic          at_max_o;
  logic          at_min_o;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  updown_key_counter #(
    .COUNT_WIDTH  (CW),
    .MAX_VALUE    (MAXV),
    .DEB_DELAY    (DEB),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .up_key_i   (up_key_i),
    .down_key_i (down_key_i),
    .clr_key_i  (clr_key_i),
    .sat_mode_i (sat_mode_i),
    .count_o    (count_o),
    .wrap_o     (wrap_o),
    .at_max_o   (at_max_o),
    .at_min_o   (at_min_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_n++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // ---------------- behavioural model ----------------
  // Key k (0 up, 1 down, 2 clr). m_win[k][0] is the most recent raw sample.
  // The debounced level flips once the raw key, seen through the two-cycle
  // synchroniser, has disagreed with it for DEB samples in a row.
  // Repeat is modelled as the age (cycles since press) of a held key.
  bit m_win [3][DEB+1];
  bit m_deb [3];
  bit m_prs [3];
  bit m_act [2];
  int m_age [2];
  int m_cnt  = 0;
  bit m_wrap = 1'b0;

  function automatic bit age_steps(input int age);
    return (age == 0) || (age >= RD && ((age - RD) % RP) == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j <= DEB; j++) m_win[k][j] = 1'b0;
      m_deb[k] = 1'b0;
      m_prs[k] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_age[k] = 0;
    end
    m_cnt  = 0;
    m_wrap = 1'b0;
  endtask

  task automatic model_clock();
    bit su, sd, flip;
    bit raw [3];
    raw[0] = up_key_i;
    raw[1] = down_key_i;
    raw[2] = clr_key_i;
    su = m_act[0] && age_steps(m_age[0]);
    sd = m_act[1] && age_steps(m_age[1]);
    m_wrap = 1'b0;
    if (m_prs[2]) m_cnt = 0;
    else if (su && !sd) begin
      if (m_cnt < MAXV) m_cnt = m_cnt + 1;
      else if (!sat_mode_i) begin m_cnt = 0; m_wrap = 1'b1; end
    end else if (sd && !su) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (!sat_mode_i) begin m_cnt = MAXV; m_wrap = 1'b1; end
    end
    for (int k = 0; k < 3; k++) begin
      flip = 1'b1;
      for (int j = 1; j <= DEB; j++) if (m_win[k][j] == m_deb[k]) flip = 1'b0;
      m_prs[k] = flip && !m_deb[k];
      if (flip) m_deb[k] = !m_deb[k];
      for (int j = DEB; j >= 1; j--) m_win[k][j] = m_win[k][j-1];
      m_win[k][0] = raw[k];
    end
    for (int k = 0; k < 2; k++) begin
      if (m_prs[k]) begin m_act[k] = 1'b1; m_age[k] = 0; end
      else if (m_act[k] && m_deb[k]) m_age[k] = m_age[k] + 1;
      else m_act[k] = 1'b0;
    end
  endtask

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) model_reset();
    else model_clock();
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("count", int'(count_o), m_cnt);
      check("wrap", int'(wrap_o), int'(m_wrap));
      check("at_max", int'(at_max_o), int'(m_cnt == MAXV));
      check("at_min", int'(at_min_o), int'(m_cnt == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_to(input int target);
    int guard;
    guard = 0;
    while (edge_n < target && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (edge_n < target) begin
      n_chk++;
      $display("FAIL wait_to: reached edge %0d required %0d", edge_n, target);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       up_key_i   = v;
      1:       down_key_i = v;
      default: clr_key_i  = v;
    endcase
  endtask

  task automatic tap(input int k);
    set_key(k, 1'b1);
    tick(DEB + 2);
    set_key(k, 1'b0);
    tick(DEB + 6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  // A key driven at the negedge with edge_n == k is first sampled at edge k+1;
  // its step lands on count_o at edge k+DEB+3.
  initial begin
    int k, a;
    rstn_i = 1'b0;
    tick(3);
    rstn_i = 1'b1;
    chk_en = 1'b1;
    check("rst_count", int'(count_o), 0);
    check("rst_wrap", int'(wrap_o), 0);
    check("rst_at_max", int'(at_max_o), 0);
    check("rst_at_min", int'(at_min_o), 1);

    // 1. bouncing up key
    up_key_i = 1'b1; tick(2);
    up_key_i = 1'b0; tick(1);
    up_key_i = 1'b1; tick(2);
    up_key_i = 1'b0; tick(1);
    up_key_i = 1'b1;
    k = edge_n;
    wait_to(k + DEB + 2);
    check("t1_before", int'(count_o), 0);
    wait_to(k + DEB + 3);
    check("t1_step", int'(count_o), 1);
    up_key_i = 1'b0;
    tick(20);
    check("t1_no_extra", int'(count_o), 1);

    // 2a. hold up, wrap mode
    tap(2);
    check("t2_clr", int'(count_o), 0);
    sat_mode_i = 1'b0;
    up_key_i = 1'b1;
    k = edge_n;
    a = k + DEB + 3;
    wait_to(a);
    check("t2_first", int'(count_o), 1);
    wait_to(a + 9);
    check("t2_pre_rpt", int'(count_o), 1);
    wait_to(a + 10);
    check("t2_rpt1", int'(count_o), 2);
    wait_to(a + 31);
    check("t2_nine", int'(count_o), 9);
    check("t2_at_max", int'(at_max_o), 1);
    wait_to(a + 34);
    check("t2_wrap_cnt", int'(count_o), 0);
    check("t2_wrap_pulse", int'(wrap_o), 1);
    wait_to(a + 35);
    check("t2_wrap_end", int'(wrap_o), 0);
    wait_to(a + 40);
    check("t2_after40", int'(count_o), 2);
    up_key_i = 1'b0;
    tick(20);

    // 2b. hold up, saturate mode
    tap(2);
    sat_mode_i = 1'b1;
    up_key_i = 1'b1;
    k = edge_n;
    a = k + DEB + 3;
    wait_to(a + 31);
    check("t2s_nine", int'(count_o), 9);
    wait_to(a + 34);
    check("t2s_hold", int'(count_o), 9);
    check("t2s_no_wrap", int'(wrap_o), 0);
    wait_to(a + 40);
    check("t2s_at_max", int'(at_max_o), 1);
    up_key_i = 1'b0;
    tick(20);

    // 3. down at zero
    tap(2);
    sat_mode_i = 1'b0;
    down_key_i = 1'b1;
    k = edge_n;
    tick(DEB + 2);
    down_key_i = 1'b0;
    wait_to(k + DEB + 3);
    check("t3_wrap_cnt", int'(count_o), 9);
    check("t3_wrap_pulse", int'(wrap_o), 1);
    wait_to(k + DEB + 4);
    check("t3_wrap_end", int'(wrap_o), 0);
    tick(DEB + 6);
    tap(2);
    sat_mode_i = 1'b1;
    down_key_i = 1'b1;
    k = edge_n;
    tick(DEB + 2);
    down_key_i = 1'b0;
    wait_to(k + DEB + 3);
    check("t3s_cnt", int'(count_o), 0);
    check("t3s_at_min", int'(at_min_o), 1);
    check("t3s_no_wrap", int'(wrap_o), 0);
    tick(DEB + 6);

    // 4. simultaneous keys
    sat_mode_i = 1'b0;
    for (int i = 0; i < 5; i++) tap(0);
    check("t4_five", int'(count_o), 5);
    up_key_i = 1'b1;
    down_key_i = 1'b1;
    k = edge_n;
    tick(DEB + 2);
    up_key_i = 1'b0;
    down_key_i = 1'b0;
    wait_to(k + DEB + 3);
    check("t4_updown", int'(count_o), 5);
    tick(DEB + 6);
    tap(0);
    tap(0);
    check("t4_seven", int'(count_o), 7);
    up_key_i = 1'b1;
    clr_key_i = 1'b1;
    k = edge_n;
    tick(DEB + 2);
    up_key_i = 1'b0;
    clr_key_i = 1'b0;
    wait_to(k + DEB + 3);
    check("t4_clr_cnt", int'(count_o), 0);
    check("t4_clr_wrap", int'(wrap_o), 0);
    tick(DEB + 6);
    check("t4_clr_settle", int'(count_o), 0);

    // 5. async reset during repeat
    up_key_i = 1'b1;
    k = edge_n;
    a = k + DEB + 3;
    wait_to(a + 23);
    check("t5_six", int'(count_o), 6);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t5_rst_cnt", int'(count_o), 0);
    check("t5_rst_at_min", int'(at_min_o), 1);
    check("t5_rst_at_max", int'(at_max_o), 0);
    tick(2);
    rstn_i = 1'b1;
    k = edge_n;
    wait_to(k + DEB + 2);
    check("t5_before", int'(count_o), 0);
    wait_to(k + DEB + 3);
    check("t5_step", int'(count_o), 1);
    up_key_i = 1'b0;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
